line_fill_unit: RTL and testbench
=================================

// Module: line_fill_unit
// PURPOSE
//  Miss-refill engine sitting directly upstream of Set. Accepts one line miss,
//  issues a line-aligned read to next-level memory, and assembles BEATS beats
//  into a LINE_W line. It then writes {valid=1, line} (LINE_W+1 = 129 bits,
//  matching Set's block input) into the chosen set/way with a one-cycle enable.
//  Only one fill is outstanding at a time.
// PARAMETERS
//  ADDR_W   32   byte-address width
//  LINE_W   128  cache line data bits; Set block width = LINE_W+1
//  BEAT_W   32   memory response beat width; BEATS = LINE_W/BEAT_W (=4)
//  SET_W    6    set index bits (64 sets)
//  WAY_W    3    way select bits (8 ways)
// PORTS
//  clk            in   1         single clock, rising edge
//  rst_n          in   1         asynchronous, active-low reset
//  miss_valid     in   1         miss request present
//  miss_ready     out  1         unit idle, can accept a miss
//  miss_addr      in   ADDR_W    byte address that missed
//  miss_way       in   WAY_W     victim way chosen by replacement logic
//  mem_req_valid  out  1         read request to memory
//  mem_req_ready  in   1         memory accepts request
//  mem_req_addr   out  ADDR_W    line-aligned address (low OFFSET_W bits = 0)
//  mem_rsp_valid  in   1         one data beat present (no backpressure)
//  mem_rsp_data   in   BEAT_W    beat data, beat 0 first
//  set_en         out  1         one-cycle write strobe into Set
//  set_idx        out  SET_W     target set = addr[OFFSET_W +: SET_W]
//  set_way        out  WAY_W     target way
//  set_block      out  LINE_W+1  {1'b1 valid, assembled line}
//  fill_done      out  1         one-cycle pulse, same cycle as set_en
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; beat count=0; all outputs 0 except
//   miss_ready=1. Line buffer is cleared to 0.
//  FSM states and transitions:
//   IDLE  : miss_ready=1. On miss_valid, capture the line-aligned addr and way
//           -> REQ.
//   REQ   : mem_req_valid=1 with the captured addr, held stable until
//           mem_req_ready; on handshake -> BEAT.
//   BEAT  : each mem_rsp_valid stores a beat at line[cnt*BEAT_W +: BEAT_W]
//           (beat 0 = bits 31:0) and increments cnt. On the last beat
//           (cnt==BEATS-1) -> WRITE.
//   WRITE : set_en=1, fill_done=1 for exactly one cycle; cnt cleared; -> IDLE.
//  Latency: with mem_req_ready=1 and back-to-back beats starting the cycle
//   after the request handshake, set_en is asserted 6 cycles after the accept
//   cycle. Accept-to-accept throughput is 7 cycles.
//  miss_ready=0 in every state except IDLE. A miss presented while busy is
//   not accepted and must be held by its source.
//  mem_rsp_valid outside BEAT is ignored: no state change, buffer untouched.
//  Gaps between beats are permitted; cnt holds its value during a gap.
//  Address arithmetic: mem_req_addr = miss_addr & ~((LINE_W/8)-1),
//   so OFFSET_W = log2(LINE_W/8) = 4.
//  cnt wraps 0..BEATS-1 only; it never exceeds BEATS-1.
//  Reset mid-fill: abort immediately to IDLE. No set_en or fill_done is
//   issued, and any beats still in flight from memory are ignored.
// STRUCTURE
//  Shared package cache_pkg.v (`define constants): LINE_W, BEAT_W, SET_W,
//   WAY_W, OFFSET_W, and the FSM encodings IDLE=2'd0, REQ=2'd1, BEAT=2'd2,
//   WRITE=2'd3. Set and this unit share the same definitions.
//  One sub-module, line_assembler: beat counter plus indexed line register
//   (inputs clr and beat_valid; outputs line and last_beat). The FSM lives
//   in the top module.
// TESTING
//  1 Reset: rst_n=0 -> miss_ready=1, mem_req_valid=0, set_en=0, set_block=0.
//  2 Basic fill: miss_addr=0x0000_1234, way=5; beats 0x11111111, 0x22222222,
//    0x33333333, 0x44444444 -> mem_req_addr=0x1230; set_idx=0x23; set_way=5;
//    set_block={1'b1,128'h44444444_33333333_22222222_11111111}; set_en exactly
//    6 cycles after accept.
//  3 Stall and gaps: mem_req_ready low for 3 cycles and a 2-cycle gap between
//    beats 1 and 2 -> same line as test 2; mem_req_addr stable while waiting;
//    set_en delayed by 5 cycles.
//  4 Busy and stray beats: second miss_valid during BEAT -> miss_ready=0,
//    second miss accepted the cycle after WRITE. mem_rsp_valid while IDLE ->
//    next fill's data is uncorrupted.
//  5 Reset mid-fill: rst_n pulsed after beat 2 -> no set_en. The next fill
//    of addr 0x40 returns a correct line with set_idx=4.
//  6 Back-to-back: 3 fills with ways 0, 7, 3 -> 3 set_en pulses with matching
//    way and idx; fill_done is coincident with each set_en.

Source files
------------

// File: rtl/line_fill_unit_pkg.sv
// Shared widths, FSM encoding and address helper for the line fill unit.
// The Set array uses the same definitions so block widths always agree.
package line_fill_unit_pkg;

    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 128;
    localparam int BEAT_W   = 32;
    localparam int SET_W    = 6;
    localparam int WAY_W    = 3;
    localparam int BEATS    = LINE_W / BEAT_W;
    localparam int OFFSET_W = $clog2(LINE_W / 8);
    localparam int CNT_W    = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BEAT  = 2'd2,
        WRITE = 2'd3
    } fill_state_e;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'((LINE_W / 8) - 1);
    endfunction

endpackage

// File: rtl/line_fill_unit_if.sv
// Miss, memory and Set-write signals of the line fill unit in one bundle.
// slave is the fill unit's view; master is the surrounding cache/memory.
interface line_fill_unit_if;
    import line_fill_unit_pkg::*;

    logic                miss_valid;
    logic                miss_ready;
    logic [ADDR_W-1:0]   miss_addr;
    logic [WAY_W-1:0]    miss_way;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic                mem_rsp_valid;
    logic [BEAT_W-1:0]   mem_rsp_data;
    logic                set_en;
    logic [SET_W-1:0]    set_idx;
    logic [WAY_W-1:0]    set_way;
    logic [LINE_W:0]     set_block;
    logic                fill_done;

    modport slave (
        input  miss_valid, miss_addr, miss_way,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output miss_ready, mem_req_valid, mem_req_addr,
        output set_en, set_idx, set_way, set_block, fill_done
    );

    modport master (
        output miss_valid, miss_addr, miss_way,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  miss_ready, mem_req_valid, mem_req_addr,
        input  set_en, set_idx, set_way, set_block, fill_done
    );

endinterface

// File: rtl/line_fill_unit_line_assembler.sv
// Beat counter plus indexed line register; beat 0 lands in the low bits.
// last_beat flags the beat that completes the line.
module line_fill_unit_line_assembler
    import line_fill_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              beat_valid,
    input  logic [BEAT_W-1:0] beat_data,
    output logic [LINE_W-1:0] line,
    output logic              last_beat
);

    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] line_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            line_q <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (beat_valid) begin
            line_q[cnt*BEAT_W +: BEAT_W] <= beat_data;
            cnt <= (cnt == CNT_W'(BEATS - 1)) ? '0 : cnt + 1'b1;
        end
    end

    assign line      = line_q;
    assign last_beat = beat_valid && (cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/line_fill_unit.sv
// Miss-refill engine: one outstanding line read, beats assembled into a line,
// then a single-cycle {valid, line} write into the chosen set/way.
module line_fill_unit
    import line_fill_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    line_fill_unit_if.slave bus
);

    fill_state_e       state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [WAY_W-1:0]  way_q;
    logic              asm_clr;
    logic              beat_valid;
    logic              last_beat;
    logic [LINE_W-1:0] line;
    logic              miss_ready;
    logic              mem_req_valid;
    logic              set_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Beats are only honoured while the FSM expects them; strays are dropped.
    always_comb begin
        state_nxt     = state;
        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        set_en        = 1'b0;
        asm_clr       = 1'b0;
        beat_valid    = 1'b0;
        case (state)
            IDLE: begin
                miss_ready = 1'b1;
                if (bus.miss_valid) state_nxt = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_nxt = BEAT;
            end
            BEAT: begin
                beat_valid = bus.mem_rsp_valid;
                if (last_beat) state_nxt = WRITE;
            end
            WRITE: begin
                set_en    = 1'b1;
                asm_clr   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            way_q  <= '0;
        end else if (state == IDLE && bus.miss_valid) begin
            addr_q <= line_align(bus.miss_addr);
            way_q  <= bus.miss_way;
        end
    end

    line_fill_unit_line_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (asm_clr),
        .beat_valid (beat_valid),
        .beat_data  (bus.mem_rsp_data),
        .line       (line),
        .last_beat  (last_beat)
    );

    // The block is zero outside WRITE so the valid bit never leaks into Set.
    assign bus.miss_ready    = miss_ready;
    assign bus.mem_req_valid = mem_req_valid;
    assign bus.mem_req_addr  = addr_q;
    assign bus.set_en        = set_en;
    assign bus.fill_done     = set_en;
    assign bus.set_idx       = addr_q[OFFSET_W +: SET_W];
    assign bus.set_way       = way_q;
    assign bus.set_block     = set_en ? {1'b1, line} : '0;

endmodule

// File: tb/tb_line_fill_unit.sv
// Bench for line_fill_unit: scenario tasks drive misses and beats, and a
// negedge monitor checks each Set write against a queue of expected fills.
module tb_line_fill_unit;
    import line_fill_unit_pkg::*;

    typedef struct packed {
        logic [5:0]   idx;
        logic [2:0]   way;
        logic [128:0] block;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_fill_unit_if bus();

    line_fill_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_set_en = 0;
    exp_t sb[$];
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.set_en === 1'b1 || bus.fill_done === 1'b1) begin
            n_cmp++;
            if (bus.fill_done !== bus.set_en) begin
                n_err++;
                $display("FAIL fill_done_coincident: fill_done=%b set_en=%b", bus.fill_done, bus.set_en);
            end
        end
        if (bus.set_en === 1'b1) begin
            n_set_en++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_set_en: got set_en=1 idx=%h way=%0d, required no write", bus.set_idx, bus.set_way);
            end else begin
                mon_e = sb.pop_front();
                if (bus.set_idx !== mon_e.idx) begin
                    n_err++;
                    $display("FAIL set_idx: got %h required %h", bus.set_idx, mon_e.idx);
                end
                n_cmp++;
                if (bus.set_way !== mon_e.way) begin
                    n_err++;
                    $display("FAIL set_way: got %0d required %0d", bus.set_way, mon_e.way);
                end
                n_cmp++;
                if (bus.set_block !== mon_e.block) begin
                    n_err++;
                    $display("FAIL set_block: got %h required %h", bus.set_block, mon_e.block);
                end
            end
        end
    end

    task automatic issue_miss(input logic [31:0] addr, input logic [2:0] way,
                              input logic [127:0] line, input bit push, output int acc_cyc);
        exp_t e;
        int   t;
        if (push) begin
            e.idx   = addr[9:4];
            e.way   = way;
            e.block = {1'b1, line};
            sb.push_back(e);
        end
        bus.miss_valid = 1'b1;
        bus.miss_addr  = addr;
        bus.miss_way   = way;
        t = 0;
        while (bus.miss_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 50) begin
            n_err++;
            $display("FAIL miss_accept_timeout: miss_ready=%b after %0d cycles, required 1", bus.miss_ready, t);
        end
        acc_cyc = cyc;
        @(negedge clk);
        bus.miss_valid = 1'b0;
    endtask

    task automatic wait_req(input logic [31:0] exp_addr);
        int t;
        t = 0;
        while (!(bus.mem_req_valid === 1'b1 && bus.mem_req_ready === 1'b1) && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 50 || bus.mem_req_addr !== exp_addr) begin
            n_err++;
            $display("FAIL mem_req_addr: got %h (valid=%b) required %h", bus.mem_req_addr, bus.mem_req_valid, exp_addr);
        end
        @(negedge clk);
    endtask

    task automatic send_beats(input logic [127:0] line, input int gap1);
        for (int i = 0; i < 4; i++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = line[i*32 +: 32];
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
            if (i == 1) repeat (gap1) @(negedge clk);
        end
    endtask

    task automatic check_set_en(input string name, input int acc, input int lat);
        n_cmp++;
        if (bus.set_en !== 1'b1 || (cyc - acc) != lat) begin
            n_err++;
            $display("FAIL %s: set_en=%b at %0d cycles after accept, required 1 at %0d", name, bus.set_en, cyc - acc, lat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.miss_ready !== 1'b1) begin n_err++; $display("FAIL reset_miss_ready: got %b required 1", bus.miss_ready); end
        n_cmp++;
        if (bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_mem_req_valid: got %b required 0", bus.mem_req_valid); end
        n_cmp++;
        if (bus.set_en !== 1'b0) begin n_err++; $display("FAIL reset_set_en: got %b required 0", bus.set_en); end
        n_cmp++;
        if (bus.set_block !== 129'd0) begin n_err++; $display("FAIL reset_set_block: got %h required 0", bus.set_block); end
        n_cmp++;
        if (bus.fill_done !== 1'b0) begin n_err++; $display("FAIL reset_fill_done: got %b required 0", bus.fill_done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_fill();
        int acc;
        issue_miss(32'h0000_1234, 3'd5, 128'h44444444_33333333_22222222_11111111, 1'b1, acc);
        wait_req(32'h0000_1230);
        send_beats(128'h44444444_33333333_22222222_11111111, 0);
        check_set_en("basic_latency", acc, 6);
        n_cmp++;
        if (bus.set_idx !== 6'h23) begin n_err++; $display("FAIL basic_set_idx: got %h required 23", bus.set_idx); end
        @(negedge clk);
    endtask

    task automatic test_stall_gaps();
        int acc;
        bus.mem_req_ready = 1'b0;
        issue_miss(32'h0000_1234, 3'd5, 128'h44444444_33333333_22222222_11111111, 1'b1, acc);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0000_1230) begin
                n_err++;
                $display("FAIL stall_req_stable: valid=%b addr=%h required 1 and 00001230", bus.mem_req_valid, bus.mem_req_addr);
            end
            @(negedge clk);
        end
        bus.mem_req_ready = 1'b1;
        wait_req(32'h0000_1230);
        send_beats(128'h44444444_33333333_22222222_11111111, 2);
        check_set_en("stall_latency", acc, 11);
        @(negedge clk);
    endtask

    task automatic test_busy_stray();
        int acc_a, acc_b, acc_c;
        issue_miss(32'h0000_2050, 3'd2, 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3, 1'b1, acc_a);
        wait_req(32'h0000_2050);
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h0000_37FC;
        bus.miss_way   = 3'd6;
        n_cmp++;
        if (bus.miss_ready !== 1'b0) begin n_err++; $display("FAIL busy_miss_ready_beat: got %b required 0", bus.miss_ready); end
        send_beats(128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3, 0);
        check_set_en("busy_first_latency", acc_a, 6);
        n_cmp++;
        if (bus.miss_ready !== 1'b0) begin n_err++; $display("FAIL busy_miss_ready_write: got %b required 0", bus.miss_ready); end
        issue_miss(32'h0000_37FC, 3'd6, 128'h0F0F0F0F_12345678_9ABCDEF0_CAFEF00D, 1'b1, acc_b);
        n_cmp++;
        if (acc_b - acc_a != 7) begin n_err++; $display("FAIL busy_second_accept: got %0d cycles after first, required 7", acc_b - acc_a); end
        wait_req(32'h0000_37F0);
        send_beats(128'h0F0F0F0F_12345678_9ABCDEF0_CAFEF00D, 0);
        check_set_en("busy_second_latency", acc_b, 6);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = 32'hDEAD_BE00 + k;
            @(negedge clk);
        end
        bus.mem_rsp_valid = 1'b0;
        issue_miss(32'h0000_0188, 3'd1, 128'h55555555_66666666_77777777_88888888, 1'b1, acc_c);
        wait_req(32'h0000_0180);
        send_beats(128'h55555555_66666666_77777777_88888888, 0);
        check_set_en("stray_fill_latency", acc_c, 6);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fill();
        int acc, snap;
        issue_miss(32'h0000_0500, 3'd1, 128'h0, 1'b0, acc);
        wait_req(32'h0000_0500);
        for (int i = 0; i < 3; i++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = 32'hBAD0_0000 + i;
            @(negedge clk);
        end
        snap  = n_set_en;
        rst_n = 1'b0;
        bus.mem_rsp_data = 32'hBAD0_0003;
        @(negedge clk);
        n_cmp++;
        if (bus.miss_ready !== 1'b1 || bus.mem_req_valid !== 1'b0 || bus.set_block !== 129'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: miss_ready=%b req_valid=%b block=%h required 1/0/0", bus.miss_ready, bus.mem_req_valid, bus.set_block);
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (n_set_en != snap) begin n_err++; $display("FAIL midreset_no_set_en: got %0d writes required %0d", n_set_en, snap); end
        issue_miss(32'h0000_0040, 3'd4, 128'h13579BDF_2468ACE0_FEDCBA98_01234567, 1'b1, acc);
        wait_req(32'h0000_0040);
        send_beats(128'h13579BDF_2468ACE0_FEDCBA98_01234567, 0);
        check_set_en("midreset_refill_latency", acc, 6);
        n_cmp++;
        if (bus.set_idx !== 6'd4) begin n_err++; $display("FAIL midreset_set_idx: got %h required 04", bus.set_idx); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0]  addrs [3];
        logic [31:0]  aligned [3];
        logic [2:0]   ways [3];
        logic [127:0] lines [3];
        int           acc [3];
        addrs   = '{32'h0000_1000, 32'h0000_2FF7, 32'h0000_0ABC};
        aligned = '{32'h0000_1000, 32'h0000_2FF0, 32'h0000_0AB0};
        ways    = '{3'd0, 3'd7, 3'd3};
        lines   = '{128'hFFFFFFFF_00000000_FFFFFFFF_00000000,
                    128'h00000001_80000000_7FFFFFFF_FFFFFFFE,
                    128'hC0DEC0DE_BEEFBEEF_FACEFACE_0BADF00D};
        for (int i = 0; i < 3; i++) begin
            issue_miss(addrs[i], ways[i], lines[i], 1'b1, acc[i]);
            wait_req(aligned[i]);
            send_beats(lines[i], 0);
            check_set_en("b2b_latency", acc[i], 6);
            if (i > 0) begin
                n_cmp++;
                if (acc[i] - acc[i-1] != 7) begin
                    n_err++;
                    $display("FAIL b2b_throughput: got %0d cycles between accepts, required 7", acc[i] - acc[i-1]);
                end
            end
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0 || n_set_en != 9) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d pending, %0d writes, required 0 pending and 9 writes", sb.size(), n_set_en);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bus.miss_valid    = 1'b0;
        bus.miss_addr     = '0;
        bus.miss_way      = '0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        @(negedge clk);
        test_reset();
        test_basic_fill();
        test_stall_gaps();
        test_busy_stray();
        test_reset_mid_fill();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
